reg_data_bank: RTL and testbench

- Parametrised, double-buffered register bank; generalises the single 8-bit enabled data register to N channels of W bits.
- Writes land in per-channel staging registers. A single commit pulse transfers all staging values to the active outputs in the same clock edge, so multi-field values (e.g. time/date fields sent to the display path) update atomically.
- Sits between the bus/control FSM that writes fields and the consumers that read the active values.

---
 rtl/reg_data_bank.sv | 60 ++++++
 tb/tb_reg_data_bank.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/reg_data_bank.sv
// reg_data_bank: double-buffered N x W register bank with atomic commit
// Ports:
//   clk, reset (sync, active-low)
//   wr_en/wr_addr/wr_data : staging write
//   commit                : copy all staging to data_out on one edge
//   rd_addr -> rd_data    : registered staging readback (0 when out of range)
//   data_out              : active values, channel k at [k*W +: W]
//   dirty/pending         : per-channel and any-channel "written since commit"
//   commit_done/wr_err    : one-cycle pulses after a commit / out-of-range write
module reg_data_bank #(
   parameter int W  = 8,
   parameter int N  = 4,
   parameter int AW = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [W-1:0]    wr_data,
   input  logic            commit,
   input  logic [AW-1:0]   rd_addr,
   output logic [W-1:0]    rd_data,
   output logic [N*W-1:0]  data_out,
   output logic [N-1:0]    dirty,
   output logic            pending,
   output logic            commit_done,
   output logic            wr_err
);
   logic [W-1:0] stage [N];
   logic [N-1:0] hit;
   logic [W-1:0] rd_val;
   always_comb begin
      rd_val = '0;
      for (int k = 0; k < N; k++) begin
         hit[k] = wr_en && wr_addr == AW'(k);
         if (rd_addr == AW'(k)) rd_val = stage[k];
      end
   end
   assign pending = |dirty;
   // a commit takes the same-edge write directly so the fold lands in data_out now
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < N; k++) stage[k] <= '0;
         data_out    <= '0;
         dirty       <= '0;
         rd_data     <= '0;
         commit_done <= 1'b0;
         wr_err      <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (hit[k]) stage[k] <= wr_data;
            if (commit) data_out[k*W +: W] <= hit[k] ? wr_data : stage[k];
         end
         dirty       <= commit ? '0 : dirty | hit;
         rd_data     <= rd_val;
         commit_done <= commit;
         wr_err      <= wr_en && ~|hit;
      end
   end
endmodule

// File: tb/tb_reg_data_bank.sv
// tb_reg_data_bank: directed + random check of two bank sizes (N=4 and N=3) against a behavioural model
module tb_reg_data_bank;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        reset, wr_en, commit;
   logic [1:0]  wr_addr, rd_addr;
   logic [7:0]  wr_data;
   logic [7:0]  rd4, rd3;
   logic [31:0] do4;
   logic [23:0] do3;
   logic [3:0]  dy4;
   logic [2:0]  dy3;
   logic        p4, p3, cd4, cd3, er4, er3;
   int checks = 0, failures = 0;
   int nch [2];
   logic [7:0] stg [2][4];
   logic [7:0] act [2][4];
   bit         dty [2][4];
   logic [7:0] erd [2];
   bit         ecd [2];
   bit         eerr [2];

   reg_data_bank #(.W(8), .N(4), .AW(2)) dut4 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .rd_addr(rd_addr), .rd_data(rd4), .data_out(do4), .dirty(dy4),
      .pending(p4), .commit_done(cd4), .wr_err(er4));
   reg_data_bank #(.W(8), .N(3), .AW(2)) dut3 (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .commit(commit), .rd_addr(rd_addr), .rd_data(rd3), .data_out(do3), .dirty(dy3),
      .pending(p3), .commit_done(cd3), .wr_err(er3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_dout(input int i);
      logic [31:0] r = '0;
      for (int k = 0; k < nch[i]; k++) r[k*8 +: 8] = act[i][k];
      return r;
   endfunction

   function automatic logic [31:0] exp_dirty(input int i);
      logic [31:0] r = '0;
      for (int k = 0; k < nch[i]; k++) r[k] = dty[i][k];
      return r;
   endfunction

   task automatic tick(input bit rs, input bit we, input logic [1:0] wa, input logic [7:0] wd,
                       input bit cm, input logic [1:0] ra);
      bit hit;
      reset = rs; wr_en = we; wr_addr = wa; wr_data = wd; commit = cm; rd_addr = ra;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (!rs) begin
            for (int k = 0; k < 4; k++) begin
               stg[i][k] = '0; act[i][k] = '0; dty[i][k] = 0;
            end
            erd[i] = '0; ecd[i] = 0; eerr[i] = 0;
         end else begin
            hit = we && int'(wa) < nch[i];
            erd[i] = int'(ra) < nch[i] ? stg[i][ra] : 8'h00;
            if (hit) begin
               stg[i][wa] = wd;
               dty[i][wa] = 1;
            end
            if (cm) for (int k = 0; k < 4; k++) begin
               act[i][k] = stg[i][k];
               dty[i][k] = 0;
            end
            ecd[i] = cm;
            eerr[i] = we && !hit;
         end
      end
      @(negedge clk);
      chk("n4_data_out", do4, exp_dout(0));
      chk("n4_dirty", 32'(dy4), exp_dirty(1'b0));
      chk("n4_pending", 32'(p4), 32'(exp_dirty(0) != 0));
      chk("n4_rd_data", 32'(rd4), 32'(erd[0]));
      chk("n4_commit_done", 32'(cd4), 32'(ecd[0]));
      chk("n4_wr_err", 32'(er4), 32'(eerr[0]));
      chk("n3_data_out", 32'(do3), exp_dout(1));
      chk("n3_dirty", 32'(dy3), exp_dirty(1));
      chk("n3_pending", 32'(p3), 32'(exp_dirty(1) != 0));
      chk("n3_rd_data", 32'(rd3), 32'(erd[1]));
      chk("n3_commit_done", 32'(cd3), 32'(ecd[1]));
      chk("n3_wr_err", 32'(er3), 32'(eerr[1]));
   endtask

   initial begin
      nch[0] = 4; nch[1] = 3;
      reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0; rd_addr = '0;
      @(negedge clk);
      // reset while a write is being driven
      tick(0, 1, 2'd1, 8'h99, 0, 2'd1);
      tick(0, 1, 2'd1, 8'h99, 0, 2'd1);
      chk("plan_reset_dout", do4, 32'h0);
      chk("plan_reset_rd", 32'(rd4), 32'h0);
      // staged writes, no commit
      tick(1, 1, 2'd0, 8'h12, 0, 2'd0);
      tick(1, 1, 2'd2, 8'hA5, 0, 2'd2);
      chk("plan_staged_dout", do4, 32'h0);
      chk("plan_staged_dirty", 32'(dy4), 32'h5);
      tick(1, 0, 2'd0, 8'h00, 0, 2'd2);
      chk("plan_readback", 32'(rd4), 32'hA5);
      tick(1, 0, 2'd0, 8'h00, 1, 2'd0);
      chk("plan_commit_dout", do4, 32'h00A50012);
      chk("plan_commit_done", 32'(cd4), 32'h1);
      tick(1, 0, 2'd0, 8'h00, 0, 2'd0);
      chk("plan_commit_done_drop", 32'(cd4), 32'h0);
      // write folded into commit
      tick(1, 1, 2'd1, 8'h33, 0, 2'd1);
      tick(1, 1, 2'd1, 8'h77, 1, 2'd1);
      chk("plan_fold_ch1", 32'(do4[15:8]), 32'h77);
      chk("plan_fold_rd_old", 32'(rd4), 32'h33);
      // out-of-range write on the 3-channel bank
      tick(1, 1, 2'd3, 8'hFF, 0, 2'd3);
      chk("plan_oob_err", 32'(er3), 32'h1);
      chk("plan_oob_rd", 32'(rd3), 32'h0);
      tick(1, 0, 2'd0, 8'h00, 0, 2'd3);
      chk("plan_oob_err_drop", 32'(er3), 32'h0);
      // reset on the same edge as a commit with all channels dirty
      for (int k = 0; k < 4; k++) tick(1, 1, 2'(k), 8'(8'h40 + k), 0, 2'd0);
      chk("plan_all_dirty", 32'(dy4), 32'hF);
      tick(0, 0, 2'd0, 8'h00, 1, 2'd0);
      chk("plan_rst_commit_dout", do4, 32'h0);
      chk("plan_rst_commit_done", 32'(cd4), 32'h0);
      // back-to-back commits
      tick(1, 0, 2'd0, 8'h00, 1, 2'd0);
      tick(1, 1, 2'd3, 8'h5C, 1, 2'd3);
      chk("plan_b2b_ch3", 32'(do4[31:24]), 32'h5C);
      tick(1, 0, 2'd0, 8'h00, 1, 2'd3);
      chk("plan_b2b_done", 32'(cd4), 32'h1);
      chk("plan_b2b_dirty", 32'(dy4), 32'h0);
      // random traffic
      for (int n = 0; n < 400; n++)
         tick($urandom_range(0, 49) != 0, 1'($urandom), 2'($urandom), 8'($urandom),
              $urandom_range(0, 3) == 0, 2'($urandom));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
